frame_sched_ctrl: RTL and testbench
===================================

# frame_sched_ctrl

Sequencer for the 6-word frame datapath: captures a frame of six 9-bit words plus a 3-bit mode, dispatches each word one at a time to the shared arithmetic core over a req/ack handshake, buffers the results, and streams them out as a 6-cycle `out_valid` burst. It also drives the clock-gate enables for the input buffer, the core and the output buffer, so idle banks stop toggling when `cg_en` is set.

## Interface
- `N_WORDS`, 6: words per frame.
- `DW`, 9: data width.
- `MW`, 3: mode width.
- `TIMEOUT`, 2000: core-ack watchdog limit in cycles. Used only with `FRAME_SCHED_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cg_en`  in  1  clock-gating request, sampled on the first frame word.
- `in_valid`  in  1  frame word valid.
- `in_data`  in  DW  frame word.
- `in_mode`  in  MW  frame mode, valid on the first `in_valid` cycle only.
- `core_req`  out  1  word presented to the core.
- `core_op`  out  MW  latched mode.
- `core_a`  out  DW  word under dispatch.
- `core_idx`  out  3  index of that word, 0..5.
- `core_ack`  in  1  core accepts the word; `core_res` is valid this cycle.
- `core_res`  in  DW  core result.
- `gate_in_en`, `gate_core_en`, `gate_out_en`  out  1 each  clock-gate enables (1 = clock runs).
- `out_valid`  out  1  result burst valid.
- `out_data`  out  DW  result word; 0 whenever `out_valid` = 0.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky watchdog error flag.

## Operation
FSM states: IDLE, LOAD, ISSUE, OUT.

- **IDLE**
  - On `in_valid`: store `in_data` in ibuf[0], latch `in_mode` and `cg_en`, set wr_idx = 1, go to LOAD.
- **LOAD**
  - Each `in_valid` cycle stores `in_data` in ibuf[wr_idx].
  - After the 6th word: go to OUT if mode = 3'd7 (bypass, obuf = ibuf), otherwise go to ISSUE.
  - If `in_valid` drops before 6 words: abort the frame, return to IDLE, produce no output.
- **ISSUE**
  - `core_req` = 1, with `core_a` = ibuf[k], `core_idx` = k, `core_op` = mode.
  - All three are held stable until `core_ack`.
  - On `core_req & core_ack`: obuf[k] = `core_res`, k++.
  - Back-to-back acks are legal, giving one word per cycle.
  - After the ack for k = 5, go to OUT.
- **OUT**
  - `out_valid` = 1 for exactly 6 consecutive cycles; `out_data` = obuf[0..5] in order.
  - Then return to IDLE.
- `in_valid` is ignored in ISSUE and OUT. No queuing; the driver must wait until `busy` = 0.
- Gate enables, using the latched `cg_en` (`g`):
  - `gate_in_en` = ~g | IDLE | LOAD.
  - `gate_core_en` = ~g | ISSUE.
  - `gate_out_en` = ~g | ISSUE | OUT.
- Arithmetic is done entirely by the core. The block only moves unsigned 9-bit values and never alters them.

## Timing
- Reset: state IDLE, all indices 0, `core_req` = 0, `core_a` = 0, `core_idx` = 0, `core_op` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0, `err` = 0, buffers cleared.
- Gate enables out of reset are all 1, because latched g = 0.
- Let E be the edge that captures word 5.
  - `core_req` rises after E.
  - With `core_ack` tied high, results are stored at edges E+1..E+6.
  - `out_valid` rises at E+6 and falls at E+12.
- Bypass mode: `out_valid` rises at E+1.
- All outputs are registered.
- `rst` mid-frame returns to IDLE on the next edge. It discards the frame, clears `out_valid` immediately and clears `err`.
- `cg_en` changes during a frame take effect from the next frame only.

## Configuration
- `FRAME_SCHED_TIMEOUT_EN` defined:
  - A counter runs while `core_req` = 1 and `core_ack` = 0.
  - When the counter reaches `TIMEOUT`: obuf[k] = 0, set `err` (sticky until `rst`), advance k.
  - The counter clears on every advance.
- `FRAME_SCHED_TIMEOUT_EN` undefined:
  - ISSUE waits indefinitely for `core_ack`.
  - `err` is tied to 0 and no counter is built.

## Structure
- Package `frame_sched_pkg` holds:
  - the state enum;
  - `N_WORDS`, `DW`, `MW`;
  - `MODE_BYPASS` = 3'd7;
  - the default `TIMEOUT`.
- Sub-module `frame_sched_buf`: a 6×DW register file with a synchronous write port and a combinational read port. It is instantiated twice, as ibuf and obuf, each clocked through its own gate enable.

## Test plan
- **Basic frame.** Mode 2, data 1..6, core returns a+100 with `core_ack` held high → `out_data` 101..106 on 6 consecutive cycles; `out_valid` rises 6 cycles after E.
- **Bypass.** Mode 7, data 511, 0, 256, 3, 4, 5 → `core_req` never asserts; output is 511, 0, 256, 3, 4, 5 starting at E+1.
- **Backpressure.** `core_ack` pulses every 3rd cycle → `core_a`, `core_idx` and `core_op` stay stable while waiting; results are correct and in order.
- **Abort.** `in_valid` drops after 4 words → no `out_valid`, `busy` returns to 0; the next full frame processes correctly.
- **Gating and reset.**
  - `cg_en` = 1 → `gate_core_en` is 0 in IDLE, LOAD and OUT, and 1 only in ISSUE.
  - `rst` asserted in the 3rd OUT cycle → `out_valid` = 0 and `out_data` = 0 on the next edge.
- **Watchdog** (`FRAME_SCHED_TIMEOUT_EN`, `TIMEOUT` = 20). `core_ack` is never given for word 2 → obuf[2] = 0, `err` = 1, and the frame completes with all 6 outputs.

Source files
------------

// File: rtl/frame_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_sched_pkg                                                      |
// | Shared types and constants for the frame sequencer.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package frame_sched_pkg;

  localparam int N_WORDS         = 6;
  localparam int DW              = 9;
  localparam int MW              = 3;
  localparam int IDX_W           = 3;
  localparam int TIMEOUT_DEFAULT = 2000;

  localparam logic [MW-1:0] MODE_BYPASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // {in, core, out} enables for the state being entered; g is the latched gating request
  function automatic logic [2:0] gate_enables(input state_e st, input logic g);
    gate_enables = {~g | (st == ST_IDLE) | (st == ST_LOAD),
                    ~g | (st == ST_ISSUE),
                    ~g | (st == ST_ISSUE) | (st == ST_OUT)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sched_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_sched_ctrl_if                                                  |
// | Request/acknowledge bus between the sequencer and the arithmetic core|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface frame_sched_ctrl_if;
  import frame_sched_pkg::*;

  logic             core_req;
  logic [MW-1:0]    core_op;
  logic [DW-1:0]    core_a;
  logic [IDX_W-1:0] core_idx;
  logic             core_ack;
  logic [DW-1:0]    core_res;

  modport master (
    output core_req, core_op, core_a, core_idx,
    input  core_ack, core_res
  );

  modport slave (
    input  core_req, core_op, core_a, core_idx,
    output core_ack, core_res
  );

endinterface
`default_nettype wire

// File: rtl/frame_sched_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_sched_buf                                                      |
// | N_WORDS x DW register file, synchronous write, combinational read.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module frame_sched_buf
  import frame_sched_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clk_en,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] wr_idx,
  input  wire logic [DW-1:0]    wr_data,
  input  wire logic [IDX_W-1:0] rd_idx,
  output logic      [DW-1:0]    rd_data
);

  logic [DW-1:0] r_mem [N_WORDS];

  // clk_en stands in for the bank's gated clock; reset clears regardless of gating
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) r_mem[i] <= '0;
    end else if (clk_en && we && (wr_idx < IDX_W'(N_WORDS))) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < IDX_W'(N_WORDS)) ? r_mem[rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/frame_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_sched_ctrl                                                     |
// | Captures a 6-word frame, dispatches it to the core, streams results. |
// | Optional core-ack watchdog: define FRAME_SCHED_TIMEOUT_EN.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module frame_sched_ctrl
  import frame_sched_pkg::*;
`ifdef FRAME_SCHED_TIMEOUT_EN
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)
`endif
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             cg_en,
  input  wire logic             in_valid,
  input  wire logic [DW-1:0]    in_data,
  input  wire logic [MW-1:0]    in_mode,
  frame_sched_ctrl_if.master    core,
  output logic                  gate_in_en,
  output logic                  gate_core_en,
  output logic                  gate_out_en,
  output logic                  out_valid,
  output logic      [DW-1:0]    out_data,
  output logic                  busy,
  output logic                  err
);

  state_e           r_state;
  logic             r_g;
  logic [MW-1:0]    r_mode;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_core_req;
  logic [DW-1:0]    r_core_a;
  logic [IDX_W-1:0] r_core_idx;
  logic [MW-1:0]    r_core_op;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_busy;
  logic [2:0]       r_gates;

  logic             w_ib_we;
  logic [IDX_W-1:0] w_ib_widx;
  logic [IDX_W-1:0] w_ib_ridx;
  logic [DW-1:0]    w_ib_rdata;
  logic [DW-1:0]    w_ob_wdata;
  logic [IDX_W-1:0] w_ob_ridx;
  logic [DW-1:0]    w_ob_rdata;
  logic [DW-1:0]    w_out_word;
  logic             w_advance;
  logic             w_timeout;
  logic             w_bypass;

  assign w_bypass   = (r_mode == MODE_BYPASS);
  assign w_ib_we    = in_valid && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_ib_widx  = (r_state == ST_IDLE) ? '0 : r_wr_idx;
  // ibuf read port serves the next core word in ISSUE and the bypass stream in OUT
  assign w_ib_ridx  = (r_state == ST_OUT)   ? r_rd_idx :
                      (r_state == ST_ISSUE) ? r_k + IDX_W'(1) : '0;
  assign w_ob_ridx  = (r_state == ST_OUT) ? r_rd_idx : '0;
  assign w_advance  = (r_state == ST_ISSUE) && (core.core_ack || w_timeout);
  assign w_ob_wdata = core.core_ack ? core.core_res : '0;
  assign w_out_word = w_bypass ? w_ib_rdata : w_ob_rdata;

  frame_sched_buf u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (r_gates[2]),
    .we      (w_ib_we),
    .wr_idx  (w_ib_widx),
    .wr_data (in_data),
    .rd_idx  (w_ib_ridx),
    .rd_data (w_ib_rdata)
  );

  frame_sched_buf u_obuf (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (r_gates[0]),
    .we      (w_advance),
    .wr_idx  (r_k),
    .wr_data (w_ob_wdata),
    .rd_idx  (w_ob_ridx),
    .rd_data (w_ob_rdata)
  );

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT + 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_err;

  assign w_timeout = (r_state == ST_ISSUE) && !core.core_ack &&
                     (r_wd_cnt == c_wd_w'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_advance || (r_state != ST_ISSUE)) r_wd_cnt <= '0;
      else                                    r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_g         <= 1'b0;
      r_mode      <= '0;
      r_wr_idx    <= '0;
      r_k         <= '0;
      r_rd_idx    <= '0;
      r_core_req  <= 1'b0;
      r_core_a    <= '0;
      r_core_idx  <= '0;
      r_core_op   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_gates     <= 3'b111;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mode   <= in_mode;
            r_g      <= cg_en;
            r_wr_idx <= IDX_W'(1);
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
            r_gates  <= gate_enables(ST_LOAD, cg_en);
          end
        end
        ST_LOAD: begin
          if (!in_valid) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_wr_idx <= '0;
            r_gates  <= gate_enables(ST_IDLE, r_g);
          end else if (r_wr_idx == IDX_W'(N_WORDS - 1)) begin
            r_wr_idx <= '0;
            if (w_bypass) begin
              // first out word is registered one edge later
              r_state  <= ST_OUT;
              r_rd_idx <= '0;
              r_gates  <= gate_enables(ST_OUT, r_g);
            end else begin
              r_state    <= ST_ISSUE;
              r_k        <= '0;
              r_core_req <= 1'b1;
              r_core_a   <= w_ib_rdata;
              r_core_idx <= '0;
              r_core_op  <= r_mode;
              r_gates    <= gate_enables(ST_ISSUE, r_g);
            end
          end else begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
          end
        end
        ST_ISSUE: begin
          if (w_advance) begin
            if (r_k == IDX_W'(N_WORDS - 1)) begin
              r_state     <= ST_OUT;
              r_core_req  <= 1'b0;
              r_k         <= '0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_ob_rdata;
              r_rd_idx    <= IDX_W'(1);
              r_gates     <= gate_enables(ST_OUT, r_g);
            end else begin
              r_k        <= r_k + IDX_W'(1);
              r_core_a   <= w_ib_rdata;
              r_core_idx <= r_k + IDX_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (r_rd_idx == IDX_W'(N_WORDS)) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rd_idx    <= '0;
            r_busy      <= 1'b0;
            r_gates     <= gate_enables(ST_IDLE, r_g);
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_word;
            r_rd_idx    <= r_rd_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core.core_req = r_core_req;
  assign core.core_a   = r_core_a;
  assign core.core_idx = r_core_idx;
  assign core.core_op  = r_core_op;

  assign gate_in_en   = r_gates[2];
  assign gate_core_en = r_gates[1];
  assign gate_out_en  = r_gates[0];
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_sched_ctrl                                                  |
// | Scoreboard bench: directed frames, core model, output monitor.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_frame_sched_ctrl;
  import frame_sched_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          cg_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [MW-1:0] in_mode;
  logic          gate_in_en, gate_core_en, gate_out_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err;

  frame_sched_ctrl_if bus ();

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef FRAME_SCHED_TIMEOUT_EN
  frame_sched_ctrl #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .cg_en(cg_en), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .core(bus.master), .gate_in_en(gate_in_en),
    .gate_core_en(gate_core_en), .gate_out_en(gate_out_en), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .err(err)
  );
`else
  frame_sched_ctrl dut (
    .clk(clk), .rst(rst), .cg_en(cg_en), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .core(bus.master), .gate_in_en(gate_in_en),
    .gate_core_en(gate_core_en), .gate_out_en(gate_out_en), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .err(err)
  );
`endif

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] cur_d [6];
  logic [MW-1:0] cur_mode;
  int            ack_mode;
  int            e_cyc, rise_cyc, fall_cyc, n_out, req_cycles, exp_k, phase;
  logic          prev_valid, ack;
  logic [DW-1:0] fd [6];
  int            n0, r0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_plus(input logic [DW-1:0] d [6], input logic [DW-1:0] off);
    for (int i = 0; i < 6; i++) exp_q.push_back(d[i] + off);
  endtask

  // drives n words; returns just after the edge capturing the last word with in_valid dropped
  task automatic send_frame(input logic [MW-1:0] mode, input logic [DW-1:0] d [6],
                            input logic cg, input int n);
    cur_mode = mode;
    cur_d    = d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d[i];
      in_mode  = (i == 0) ? mode : ~mode;
      cg_en    = (i == 0) ? cg : ~cg;
    end
    @(posedge clk);
    #1;
    e_cyc    = cyc;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check(name, out_valid, 1);
  endtask

  initial begin
    rst = 1'b1; cg_en = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
    ack_mode = 0; bus.core_ack = 1'b0; bus.core_res = '0;
    e_cyc = 0; rise_cyc = 0; fall_cyc = 0; n_out = 0; req_cycles = 0;
    exp_k = 0; phase = 0; prev_valid = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_core_req", bus.core_req, 0);
    check("rst_core_a", bus.core_a, 0);
    check("rst_core_idx", bus.core_idx, 0);
    check("rst_core_op", bus.core_op, 0);
    check("rst_err", err, 0);
    check("rst_gates", {gate_in_en, gate_core_en, gate_out_en}, 3'b111);
    @(negedge clk);
    rst = 1'b0;

    // core model and output monitor
    fork
      forever begin
        @(negedge clk);
        if (bus.core_req) begin
          req_cycles++;
          if (ack_mode != 2 && exp_k < 6) begin
            check("core_idx", bus.core_idx, exp_k);
            check("core_a", bus.core_a, cur_d[exp_k]);
            check("core_op", bus.core_op, cur_mode);
          end
          case (ack_mode)
            1:       ack = (phase == 2);
            2:       ack = (bus.core_idx != 3'd2);
            default: ack = 1'b1;
          endcase
          phase        = (phase == 2) ? 0 : phase + 1;
          bus.core_ack = ack;
          bus.core_res = bus.core_a + 9'd100;
          if (ack) exp_k++;
        end else begin
          exp_k        = 0;
          phase        = 0;
          bus.core_ack = (ack_mode == 0);
          bus.core_res = '0;
        end
        if (out_valid) begin
          n_out++;
          if (!prev_valid) rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL out_unexpected: got word %0d expected no output", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end else begin
          check("out_data_idle", out_data, 0);
          if (prev_valid) fall_cyc = cyc;
        end
        prev_valid = out_valid;
      end
    join_none

    // basic frame
    fd = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
    push_plus(fd, 9'd100);
    n0 = n_out;
    send_frame(3'd2, fd, 1'b0, 6);
    check("basic_req_after_E", bus.core_req, 1);
    wait_idle(100, "basic_idle");
    check("basic_rise", rise_cyc - e_cyc, 6);
    check("basic_fall", fall_cyc - e_cyc, 12);
    check("basic_count", n_out - n0, 6);
    check("basic_drained", exp_q.size(), 0);

    // bypass
    fd = '{9'd511, 9'd0, 9'd256, 9'd3, 9'd4, 9'd5};
    push_plus(fd, 9'd0);
    n0 = n_out; r0 = req_cycles;
    send_frame(3'd7, fd, 1'b0, 6);
    wait_idle(100, "bypass_idle");
    check("bypass_rise", rise_cyc - e_cyc, 1);
    check("bypass_fall", fall_cyc - e_cyc, 7);
    check("bypass_no_req", req_cycles - r0, 0);
    check("bypass_count", n_out - n0, 6);

    // backpressure
    ack_mode = 1;
    fd = '{9'd400, 9'd7, 9'd250, 9'd9, 9'd300, 9'd11};
    push_plus(fd, 9'd100);
    n0 = n_out;
    send_frame(3'd3, fd, 1'b0, 6);
    wait_idle(200, "bp_idle");
    check("bp_count", n_out - n0, 6);
    check("bp_drained", exp_q.size(), 0);
    ack_mode = 0;

    // abort after 4 words, gating requested
    fd = '{9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4};
    n0 = n_out;
    send_frame(3'd5, fd, 1'b1, 4);
    check("gates_load", {gate_in_en, gate_core_en, gate_out_en}, 3'b100);
    wait_idle(20, "abort_idle");
    repeat (10) @(negedge clk);
    check("abort_no_out", n_out - n0, 0);
    check("gates_idle_after_abort", {gate_in_en, gate_core_en, gate_out_en}, 3'b100);

    fd = '{9'd50, 9'd51, 9'd52, 9'd53, 9'd54, 9'd55};
    push_plus(fd, 9'd100);
    n0 = n_out;
    send_frame(3'd1, fd, 1'b0, 6);
    wait_idle(100, "post_abort_idle");
    check("post_abort_count", n_out - n0, 6);
    check("post_abort_rise", rise_cyc - e_cyc, 6);

`ifdef FRAME_SCHED_TIMEOUT_EN
    ack_mode = 2;
    fd = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
    exp_q.push_back(9'd101); exp_q.push_back(9'd102); exp_q.push_back(9'd0);
    exp_q.push_back(9'd104); exp_q.push_back(9'd105); exp_q.push_back(9'd106);
    n0 = n_out;
    send_frame(3'd2, fd, 1'b0, 6);
    wait_idle(300, "wd_idle");
    check("wd_err", err, 1);
    check("wd_count", n_out - n0, 6);
    ack_mode = 0;
`endif

    // gating through a full frame
    fd = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
    push_plus(fd, 9'd100);
    send_frame(3'd2, fd, 1'b1, 6);
    check("gates_issue", {gate_in_en, gate_core_en, gate_out_en}, 3'b011);
    wait_valid(50, "cg_valid");
    check("gates_out", {gate_in_en, gate_core_en, gate_out_en}, 3'b001);
    wait_idle(50, "cg_idle");
    check("gates_idle", {gate_in_en, gate_core_en, gate_out_en}, 3'b100);

    // reset in the 3rd OUT cycle
    push_plus(fd, 9'd100);
    send_frame(3'd2, fd, 1'b1, 6);
    wait_valid(50, "rst_frame_valid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_gates", {gate_in_en, gate_core_en, gate_out_en}, 3'b111);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
